// File: rtl/dmem_access_unit_if.sv
// Bundle between the MEM stage, the data-memory access unit and the L1 data cache port.
// The unit itself uses the slave view; the pipeline/cache side uses the master view.
interface dmem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_write;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              advance;
  logic              flush;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_byte_enable;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  logic [DATA_W-1:0] rdata_out;
  logic              access_done;
  logic              mem_stall;

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, advance, flush,
    input  mem_rdata, mem_resp,
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output rdata_out, access_done, mem_stall
  );

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, advance, flush,
    output mem_rdata, mem_resp,
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  rdata_out, access_done, mem_stall
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory front end: turns a level-held load/store into registered cache
// strobes held until mem_resp, formats load data, and raises mem_stall while busy.
module dmem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              stall;
  logic              squash;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_write;
  logic              lat_byte;
  logic              req_changed;
  logic [1:0]        req_be;
  logic [DATA_W-1:0] req_wfmt;
  logic [DATA_W-1:0] rd_fmt;

  assign req_changed = (bus.req_addr != lat_addr) || (bus.req_write != lat_write);
  assign req_be      = bus.req_byte ? (bus.req_addr[0] ? 2'b10 : 2'b01) : 2'b11;
  assign req_wfmt    = bus.req_byte ? {2{bus.req_wdata[7:0]}} : bus.req_wdata;
  assign rd_fmt      = lat_byte ? {8'h00, (lat_addr[0] ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0])}
                                : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_resp) next_state = (squash || bus.flush) ? IDLE : HOLD;
      end
      HOLD: begin
        // Advance and flush both retire the held result before a changed request is considered.
        if (bus.advance || bus.flush) begin
          next_state = IDLE;
        end else if (bus.req_valid && req_changed) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
    stall = accept || (state == BUSY);
  end

  assign bus.mem_stall = stall;

  // NOTE: reset is sampled synchronously and clears every register, including latched request fields.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_addr            <= '0;
      lat_write           <= 1'b0;
      lat_byte            <= 1'b0;
      squash              <= 1'b0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_address     <= '0;
      bus.mem_byte_enable <= 2'b00;
      bus.mem_wdata       <= '0;
      bus.rdata_out       <= '0;
      bus.access_done     <= 1'b0;
    end else begin
      bus.access_done <= 1'b0;
      if (accept) begin
        lat_addr            <= bus.req_addr;
        lat_write           <= bus.req_write;
        lat_byte            <= bus.req_byte;
        squash              <= 1'b0;
        bus.mem_read        <= !bus.req_write;
        bus.mem_write       <= bus.req_write;
        bus.mem_address     <= {bus.req_addr[ADDR_W-1:1], 1'b0};
        bus.mem_byte_enable <= req_be;
        bus.mem_wdata       <= req_wfmt;
      end else if (state == BUSY) begin
        if (bus.flush) squash <= 1'b1;
        if (bus.mem_resp) begin
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          // A squashed access still completes at the cache but leaves no trace in the pipeline.
          if (!squash && !bus.flush) begin
            bus.access_done <= 1'b1;
            if (!lat_write) bus.rdata_out <= rd_fmt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a vector table of single accesses plus hand-written
// sequences for LDI re-request, advance collision, flush mid-access and reset mid-access.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic        wr;
    logic        is_byte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
    logic [15:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  always @(negedge clk) if (bus.access_done === 1'b1) done_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic wr, input logic is_byte, input logic [15:0] addr,
                           input logic [15:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_byte  = is_byte;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.advance   = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // Cache model: waits for a strobe, answers on the lat-th strobe cycle, returns at the done cycle.
  task automatic serve(input int lat, input logic [15:0] data, input int flush_at,
                       output int wait_cyc, output int strobe_cyc,
                       output logic [15:0] cap_addr, output logic [1:0] cap_be,
                       output logic [15:0] cap_wdata, output logic cap_rd, output logic cap_wr,
                       output logic stable);
    wait_cyc = 0; strobe_cyc = 0; stable = 1'b1;
    cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_rd = 1'b0; cap_wr = 1'b0;
    while (!(bus.mem_read || bus.mem_write) && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    cap_addr = bus.mem_address; cap_be = bus.mem_byte_enable; cap_wdata = bus.mem_wdata;
    cap_rd = bus.mem_read; cap_wr = bus.mem_write;
    while ((bus.mem_read || bus.mem_write) && strobe_cyc < lat + 5) begin
      strobe_cyc++;
      if (bus.mem_read !== cap_rd || bus.mem_write !== cap_wr || bus.mem_stall !== 1'b1 ||
          bus.mem_address !== cap_addr) stable = 1'b0;
      bus.flush = (strobe_cyc == flush_at);
      if (bus.flush) bus.req_valid = 1'b0;
      if (strobe_cyc == lat) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = data;
      end
      @(negedge clk);
      bus.mem_resp = 1'b0;
    end
    bus.flush = 1'b0;
  endtask

  task automatic retire();
    bus.advance   = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    check("stall_at_advance", bus.mem_stall, 1'b0);
    @(negedge clk);
    bus.advance = 1'b0;
    check("done_one_cycle", bus.access_done, 1'b0);
  endtask

  task automatic check_done(input string tag, input logic [15:0] exp_rdata);
    check({tag, "_done"}, bus.access_done, 1'b1);
    check({tag, "_stall"}, bus.mem_stall, 1'b0);
    check({tag, "_strobe_drop"}, {bus.mem_read, bus.mem_write}, 2'b00);
    check({tag, "_rdata"}, bus.rdata_out, exp_rdata);
  endtask

  int          wc, sc, d0;
  logic [15:0] ca, cw;
  logic [1:0]  cb;
  logic        crd, cwr, stb;

  initial begin
    //           wr    byte  addr      wdata     rdata     lat e_addr    e_be   e_wdata   e_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h3006, 16'h0000, 16'hBEEF, 3, 16'h3006, 2'b11, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h4001, 16'h0000, 16'h12AB, 1, 16'h4000, 2'b10, 16'h0000, 16'h0012};
    vecs[2] = '{1'b0, 1'b1, 16'h4000, 16'h0000, 16'h12AB, 2, 16'h4000, 2'b01, 16'h0000, 16'h00AB};
    vecs[3] = '{1'b1, 1'b1, 16'h5001, 16'h00C3, 16'h7777, 2, 16'h5000, 2'b10, 16'hC3C3, 16'h00AB};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'hA55A, 16'h0000, 1, 16'h1234, 2'b11, 16'hA55A, 16'h00AB};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h9A00, 1, 16'hFFFE, 2'b10, 16'h0000, 16'h009A};
    vecs[6] = '{1'b1, 1'b1, 16'h0000, 16'h1234, 16'h5555, 3, 16'h0000, 2'b01, 16'h3434, 16'h009A};

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.advance = 1'b0; bus.flush = 1'b0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_strobes", {bus.mem_read, bus.mem_write, bus.access_done}, 3'b000);
    check("rst_addr", bus.mem_address, 16'h0000);
    check("rst_be_wdata", {bus.mem_byte_enable, bus.mem_wdata}, 18'h0);
    check("rst_rdata", bus.rdata_out, 16'h0000);
    check("rst_stall", bus.mem_stall, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_req(vecs[i].wr, vecs[i].is_byte, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_stall_req", i), bus.mem_stall, 1'b1);
      serve(vecs[i].lat, vecs[i].rdata, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
      check($sformatf("v%0d_strobe_latency", i), wc, 1);
      check($sformatf("v%0d_strobe_cycles", i), sc, vecs[i].lat);
      check($sformatf("v%0d_addr", i), ca, vecs[i].e_addr);
      check($sformatf("v%0d_be", i), cb, vecs[i].e_be);
      check($sformatf("v%0d_wdata", i), cw, vecs[i].e_wdata);
      check($sformatf("v%0d_rd_wr", i), {crd, cwr}, {!vecs[i].wr, vecs[i].wr});
      check($sformatf("v%0d_held", i), stb, 1'b1);
      check_done($sformatf("v%0d", i), vecs[i].e_rdata);
      retire();
    end

    // LDI: first read returns the pointer, the changed address in HOLD launches the second read.
    d0 = done_count;
    start_req(1'b0, 1'b0, 16'h2000, 16'h0000);
    serve(2, 16'h6000, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
    check("ldi1_addr", ca, 16'h2000);
    check_done("ldi1", 16'h6000);
    bus.req_addr = 16'h6000;
    #1;
    check("ldi_hold_rereq_stall", bus.mem_stall, 1'b1);
    serve(2, 16'h1357, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
    check("ldi2_latency", wc, 1);
    check("ldi2_addr", ca, 16'h6000);
    check_done("ldi2", 16'h1357);

    // Advance together with a changed request: advance wins, request taken from IDLE a cycle later.
    bus.advance  = 1'b1;
    bus.req_addr = 16'h0800;
    #1;
    check("collide_stall", bus.mem_stall, 1'b0);
    @(negedge clk);
    bus.advance = 1'b0;
    #1;
    check("ldi_done_pulses", done_count - d0, 2);
    check("collide_no_strobe", bus.mem_read, 1'b0);
    check("collide_idle_stall", bus.mem_stall, 1'b1);
    serve(1, 16'h2468, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
    check("collide_latency", wc, 1);
    check("collide_addr", ca, 16'h0800);
    check_done("collide", 16'h2468);
    retire();

    // Flush mid-access: read stays up until mem_resp, no done pulse, result untouched, back to IDLE.
    d0 = done_count;
    start_req(1'b0, 1'b0, 16'h7000, 16'h0000);
    serve(3, 16'hDEAD, 2, wc, sc, ca, cb, cw, crd, cwr, stb);
    check("flush_strobe_cycles", sc, 3);
    check("flush_read_held", {crd, stb}, 2'b11);
    check("flush_no_done", bus.access_done, 1'b0);
    check("flush_rdata_kept", bus.rdata_out, 16'h2468);
    start_req(1'b0, 1'b0, 16'h7000, 16'h0000);
    #1;
    check("flush_back_to_idle", bus.mem_stall, 1'b1);
    check("flush_done_count", done_count - d0, 0);
    serve(1, 16'h0BAD, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
    check_done("after_flush", 16'h0BAD);
    retire();

    // A response outside BUSY is ignored.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check("stray_resp_done", bus.access_done, 1'b0);
    check("stray_resp_rdata", bus.rdata_out, 16'h0BAD);

    // Reset mid-BUSY abandons the access; a fresh request then completes normally.
    start_req(1'b1, 1'b0, 16'h3000, 16'h1111);
    @(negedge clk);
    check("rst_busy_strobe", bus.mem_write, 1'b1);
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst2_strobes", {bus.mem_read, bus.mem_write, bus.access_done}, 3'b000);
    check("rst2_addr_wdata", {bus.mem_address, bus.mem_wdata}, 32'h0);
    check("rst2_be_rdata", {bus.mem_byte_enable, bus.rdata_out}, 18'h0);
    check("rst2_stall", bus.mem_stall, 1'b0);
    start_req(1'b0, 1'b0, 16'h0102, 16'h0000);
    serve(2, 16'h4242, 0, wc, sc, ca, cb, cw, crd, cwr, stb);
    check("post_rst_latency", wc, 1);
    check("post_rst_addr", ca, 16'h0102);
    check_done("post_rst", 16'h4242);
    retire();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage data-memory front end. Sits directly downstream of the LDI/STI sequencing control and the MEM-stage address/data muxes, and upstream of the L1 data cache port.
- Converts a level-held MEM-stage request into a registered cache read or write strobe, held until mem_resp.
- Formats byte/word read data and holds the result until the pipeline advances.
- Produces mem_stall so the MEM stage can freeze the pipeline.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits; fixed at 16 for byte-lane logic.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  MEM stage holds a load/store this cycle
- req_write  in  1  1 = store (STR/STB/STI), 0 = load
- req_byte  in  1  1 = byte op (LDB/STB)
- req_addr  in  ADDR_W  byte address from MEM-stage address mux
- req_wdata  in  DATA_W  store data
- advance  in  1  pipeline latches MEM/WB this cycle
- flush  in  1  squash the current MEM-stage instruction
- mem_address  out  ADDR_W  word-aligned cache address
- mem_read  out  1  cache read strobe
- mem_write  out  1  cache write strobe
- mem_byte_enable  out  2  byte lanes
- mem_wdata  out  DATA_W  cache write data
- mem_rdata  in  DATA_W  cache read data
- mem_resp  in  1  cache completion
- rdata_out  out  DATA_W  formatted load result
- access_done  out  1  one-cycle pulse when the cache access completes
- mem_stall  out  1  MEM stage must hold

Behaviour:
- States: IDLE, BUSY, HOLD. Sequential logic updates on posedge clk.
- Reset (reset_n=0 at an edge):
  - State goes to IDLE.
  - mem_read, mem_write, access_done, rdata_out, mem_address, mem_wdata and mem_byte_enable all go to 0.
  - Reset during BUSY abandons the access; the cache is assumed reset alongside.
- IDLE:
  - If req_valid && !flush: latch addr/write/byte/wdata; go to BUSY.
  - mem_stall is combinational: (state==IDLE && req_valid && !flush) || state==BUSY.
- BUSY: mem_read = !latched_write, mem_write = latched_write, both held constant until mem_resp.
  - mem_address = {latched_addr[15:1],1'b0}.
  - mem_byte_enable: word op gives 2'b11; byte op gives addr[0] ? 2'b10 : 2'b01.
  - mem_wdata: word op gives wdata; byte op gives {wdata[7:0],wdata[7:0]}.
  - On mem_resp:
    - Strobes drop next cycle.
    - rdata_out <= formatted data: word op gives mem_rdata; byte op gives {8'h00, selected byte}, high byte when addr[0]=1.
    - For stores, rdata_out holds its previous value.
    - access_done pulses for 1 cycle; go to HOLD.
  - Minimum latency: req_valid at cycle 0, strobe at cycle 1, done at cycle N+1 for an N-cycle cache response.
- flush in BUSY: recorded in a sticky squash bit, and the access still completes (no abort of an in-flight cache op). On mem_resp, go to IDLE without an access_done pulse and leave rdata_out unchanged.
- HOLD: rdata_out stable, mem_stall=0.
  - advance=1: go to IDLE.
  - Otherwise, if req_valid && (req_addr != latched_addr || req_write != latched_write): treat as a new request (e.g. the second LDI/STI access). Re-latch and go to BUSY next cycle; mem_stall=1 combinationally that cycle.
  - flush in HOLD: go to IDLE.
- Simultaneous advance and a changed request in HOLD: advance wins and goes to IDLE; the new request is taken from IDLE on the next cycle.
- mem_resp outside BUSY is ignored.
- Address wrap: 16'hFFFF is treated as a byte op at word address 16'hFFFE with lane 2'b10; there is no carry.

Test Plan:
- LDR word, req_addr=0x3006, cache resp 3 cycles after strobe, mem_rdata=0xBEEF -> mem_read high for 3 cycles, address 0x3006, byte_enable 2'b11; access_done pulse; rdata_out=0xBEEF; stall deasserts the same cycle done pulses.
- LDB at odd address 0x4001, mem_rdata=0x12AB -> byte_enable 2'b10, rdata_out=0x0012. The same at 0x4000 gives rdata_out=0x00AB.
- STB at 0x5001, wdata=0x00C3 -> mem_write with mem_wdata=0xC3C3, byte_enable 2'b10, address 0x5000; rdata_out unchanged.
- LDI sequence: addr 0x2000 returns 0x6000, then the upstream switches req_addr to 0x6000 while in HOLD without advance -> second BUSY with address 0x6000; two access_done pulses; final rdata_out = second read data.
- flush asserted mid-BUSY -> mem_read held until mem_resp; no access_done; next state IDLE; rdata_out keeps its prior value.
- reset_n low mid-BUSY for 1 cycle -> all outputs 0 next cycle, state IDLE; a subsequent request completes normally.
